mem_port_arbiter: RTL and testbench

//  Shares one single-ported byte memory between the fetch stage (32-bit reads) and the

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported byte memory between
// fetch (32-bit reads) and load/store (64-bit reads/writes).
//
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   if_*            fetch port: req/addr in; gnt/rvalid/rdata/err out
//   dm_*            data port: req/we/addr/wdata in; gnt/rvalid/rdata/err out
//   mem_*           memory side: en/we/addr/wdata out; rdata in,
//                   valid MEM_LAT cycles after the mem_en strobe
module mem_port_arbiter #(
  parameter int unsigned     MEM_LAT    = 1,
  parameter int unsigned     STARVE_MAX = 4,
  parameter longint unsigned MEM_BYTES  = 64'd524288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [63:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [LW-1:0] LAT_LD = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);
  localparam logic [64:0]   LIMIT  = {1'b0, MEM_BYTES};

  state_t        state;
  logic [LW-1:0] lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          own_dm;
  logic          own_st;

  logic          starved;
  logic          win_dm;
  logic          win_if;
  logic          in_range;
  logic [64:0]   acc_end;

  // Range check is done on 65 bits so an address near
  // 2^64 cannot wrap around into the valid range.
  always_comb begin
    starved  = if_req && (starve_cnt == S_MAX);
    win_dm   = dm_req && !starved;
    win_if   = if_req && !win_dm;
    acc_end  = win_dm ? ({1'b0, dm_addr} + 65'd8)
                      : ({1'b0, if_addr} + 65'd4);
    in_range = (acc_end <= LIMIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      own_dm     <= 1'b0;
      own_st     <= 1'b0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      dm_gnt     <= 1'b0;
      dm_rvalid  <= 1'b0;
      dm_rdata   <= '0;
      dm_err     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if_gnt <= 1'b0;
      dm_gnt <= 1'b0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (win_dm || win_if) begin
            own_dm   <= win_dm;
            own_st   <= win_dm && dm_we;
            if_gnt   <= win_if;
            dm_gnt   <= win_dm;
            mem_addr <= win_dm ? dm_addr : if_addr;
            if (win_dm) begin
              mem_wdata <= dm_wdata;
            end
            if (win_if) begin
              starve_cnt <= '0;
            end else if (if_req && starve_cnt != S_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            if (in_range) begin
              state   <= WAIT;
              mem_en  <= 1'b1;
              mem_we  <= win_dm && dm_we;
              lat_cnt <= LAT_LD;
            end else begin
              // Error response: skip memory, respond next cycle.
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            state     <= RESP;
            if_rvalid <= !own_dm;
            dm_rvalid <= own_dm;
            if (own_dm) begin
              dm_rdata <= own_st ? 64'd0 : mem_rdata;
            end else begin
              if_rdata <= mem_rdata[31:0];
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (if_rvalid || dm_rvalid) begin
            state     <= IDLE;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_err    <= 1'b0;
            dm_err    <= 1'b0;
          end else begin
            // Reached only on the error path, one cycle after gnt.
            if_rvalid <= !own_dm;
            dm_rvalid <= own_dm;
            if_err    <= !own_dm;
            dm_err    <= own_dm;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a transaction-level
// reference model for mem_port_arbiter (MEM_LAT=1 and MEM_LAT=3).
module tb_mem_port_arbiter;

  localparam int unsigned     L1   = 1;
  localparam int unsigned     L3   = 3;
  localparam int unsigned     SMAX = 4;
  localparam longint unsigned MB   = 64'd524288;
  localparam logic [63:0]     JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid, dm_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic        if3_req, if3_gnt, if3_rvalid, if3_err;
  logic [63:0] if3_addr;
  logic [31:0] if3_rdata;
  logic        dm3_req, dm3_we, dm3_gnt, dm3_rvalid, dm3_err;
  logic [63:0] dm3_addr, dm3_wdata, dm3_rdata;
  logic        mem3_en, mem3_we;
  logic [63:0] mem3_addr, mem3_wdata, mem3_rdata;

  mem_port_arbiter #(.MEM_LAT(L1), .STARVE_MAX(SMAX), .MEM_BYTES(MB)) u_d1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(L3), .STARVE_MAX(SMAX), .MEM_BYTES(MB)) u_d3 (
    .clk(clk), .reset(reset),
    .if_req(if3_req), .if_addr(if3_addr), .if_gnt(if3_gnt),
    .if_rvalid(if3_rvalid), .if_rdata(if3_rdata), .if_err(if3_err),
    .dm_req(dm3_req), .dm_we(dm3_we), .dm_addr(dm3_addr),
    .dm_wdata(dm3_wdata), .dm_gnt(dm3_gnt), .dm_rvalid(dm3_rvalid),
    .dm_rdata(dm3_rdata), .dm_err(dm3_err),
    .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr),
    .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
  );

  bit [7:0] mem [longint unsigned];
  bit [7:0] ref_mem [longint unsigned];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  function automatic void chk_s(string nm, string act, string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s want %s", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] mrd(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (mem.exists(a + 64'(i))) v[i*8 +: 8] = mem[a + 64'(i)];
    return v;
  endfunction

  function automatic logic [63:0] rrd(input logic [63:0] a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++)
      if (ref_mem.exists(a + 64'(i))) v[i*8 +: 8] = ref_mem[a + 64'(i)];
    return v;
  endfunction

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) begin
      mem[a + 64'(i)] = d[i*8 +: 8];
      ref_mem[a + 64'(i)] = d[i*8 +: 8];
    end
  endtask

  // Memory models: data valid only in the single cycle that
  // sits MEM_LAT-1 cycles after the strobe, junk otherwise.
  int unsigned since1, since3;
  logic [63:0] a1_q, a3_q;
  int wcnt = 0, ecnt = 0, e3cnt = 0;

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      since1 = 100;
      mem_rdata = JUNK;
    end else begin
      if (mem_en) begin
        since1 = 0;
        a1_q = mem_addr;
        ecnt++;
        if (mem_we) begin
          wcnt++;
          for (int i = 0; i < 8; i++)
            mem[mem_addr + 64'(i)] = mem_wdata[i*8 +: 8];
        end
      end else if (since1 < 100) begin
        since1++;
      end
      mem_rdata = (since1 == L1 - 1) ? mrd(a1_q) : JUNK;
    end
  end

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      since3 = 100;
      mem3_rdata = JUNK;
    end else begin
      if (mem3_en) begin
        since3 = 0;
        a3_q = mem3_addr;
        e3cnt++;
      end else if (since3 < 100) begin
        since3++;
      end
      mem3_rdata = (since3 == L3 - 1) ? mrd(a3_q) : JUNK;
    end
  end

  // Transaction model for u_d1: one record for the access in
  // flight, with the cycles at which each event must appear.
  bit          t_valid, t_dm, t_err, t_st, pick_dm;
  int          t_g, t_rv, nfree, starve;
  logic [63:0] t_addr, t_wd, t_rd;
  string       gseq = "";

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t_valid = 1'b0;
      nfree = 0;
      starve = 0;
    end else begin
      cyc++;
      if (t_valid && t_st && !t_err && cyc == t_rv)
        for (int i = 0; i < 8; i++)
          ref_mem[t_addr + 64'(i)] = t_wd[i*8 +: 8];
      if (cyc >= nfree && (if_req || dm_req)) begin
        pick_dm = dm_req && !(if_req && starve == int'(SMAX));
        if (!pick_dm) starve = 0;
        else if (if_req && starve < int'(SMAX)) starve++;
        if (pick_dm) gseq = {gseq, "D"};
        else gseq = {gseq, "F"};
        t_dm = pick_dm;
        t_addr = pick_dm ? dm_addr : if_addr;
        t_st = pick_dm && dm_we;
        t_wd = dm_wdata;
        t_err = pick_dm ? (t_addr > MB - 64'd8) : (t_addr > MB - 64'd4);
        t_g = cyc;
        t_rv = t_err ? cyc + 1 : cyc + int'(L1);
        nfree = t_err ? cyc + 3 : cyc + int'(L1) + 2;
        if (t_err || t_st) t_rd = '0;
        else if (pick_dm) t_rd = rrd(t_addr);
        else t_rd = {32'd0, rrd(t_addr) & 64'hFFFF_FFFF};
        t_valid = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset && chk_on) begin
      bit g, rv, men;
      g = t_valid && cyc == t_g;
      rv = t_valid && cyc == t_rv;
      men = g && !t_err;
      chk("ctl", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid,
                      if_err, dm_err, mem_en, mem_we}),
          64'({g && !t_dm, g && t_dm, rv && !t_dm, rv && t_dm,
               rv && !t_dm && t_err, rv && t_dm && t_err,
               men, men && t_st}));
      chk("if_rdata", 64'(if_rdata), (rv && !t_dm) ? t_rd : 64'd0);
      chk("dm_rdata", dm_rdata, (rv && t_dm) ? t_rd : 64'd0);
      if (t_valid && !t_err && cyc >= t_g && cyc < t_g + int'(L1)) begin
        chk("mem_addr", mem_addr, t_addr);
        if (t_st) chk("mem_wdata", mem_wdata, t_wd);
      end
    end
  end

  task automatic dm_op(input logic we, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd,
                       output logic er, output int gc, output int rc,
                       output int sc, output logic mg,
                       output logic [63:0] ma);
    int n;
    @(negedge clk);
    dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd; sc = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm_gnt && n < 20);
    chk("dm_gnt_seen", 64'(dm_gnt), 64'd1);
    gc = cyc; mg = mem_en; ma = mem_addr;
    dm_req = 1'b0; dm_we = 1'b0;
    n = 0;
    while (!dm_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("dm_rvalid_seen", 64'(dm_rvalid), 64'd1);
    rc = cyc; rd = dm_rdata; er = dm_err;
  endtask

  task automatic if_op(input logic [63:0] a, output logic [31:0] rd,
                       output logic er, output int gc, output int rc);
    int n;
    @(negedge clk);
    if_req = 1'b1; if_addr = a;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_gnt && n < 20);
    chk("if_gnt_seen", 64'(if_gnt), 64'd1);
    gc = cyc;
    if_req = 1'b0;
    n = 0;
    while (!if_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("if_rvalid_seen", 64'(if_rvalid), 64'd1);
    rc = cyc; rd = if_rdata; er = if_err;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd, ma;
    logic [31:0] r32;
    logic er, mg;
    int gc, rc, sc, n, k;
    string obs;

    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
    dm_addr = '0; dm_wdata = '0;
    if3_req = 0; if3_addr = '0; dm3_req = 0; dm3_we = 0;
    dm3_addr = '0; dm3_wdata = '0;
    preload(64'h100, 64'h1122334455667788);
    preload(64'h300, 64'hA5A5A5A5_C3C3C3C3);
    preload(64'h400, 64'h0404040404040404);
    preload(64'h2000, 64'h8877665544332211);
    preload(MB - 64'd8, 64'h0123456789ABCDEF);

    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({if_gnt, dm_gnt, if_rvalid, dm_rvalid,
                        if_err, dm_err, mem_en, mem_we}), 64'd0);
    chk("rst_rdata", {if_rdata, 32'd0} | dm_rdata, 64'd0);
    chk("rst_mem_bus", mem_addr | mem_wdata, 64'd0);
    chk("rst_d3_ctl", 64'({if3_gnt, dm3_gnt, if3_rvalid, dm3_rvalid,
                           mem3_en, mem3_we}), 64'd0);
    #2 reset = 1'b1;
    chk_on = 1'b1;

    // Reset in the middle of a store, with starvation count raised.
    @(negedge clk);
    if_req = 1; if_addr = 64'h300;
    dm_req = 1; dm_we = 0; dm_addr = 64'h400;
    n = 0; k = 0;
    while (k < 2 && n < 100) begin
      @(negedge clk); n++;
      if (dm_gnt) k++;
    end
    dm_we = 1; dm_addr = 64'h500; dm_wdata = 64'hFEED_FACE_0BAD_F00D;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(dm_gnt && mem_we) && n < 50);
    chk("t1_store_strobe", 64'({mem_en, mem_we}), 64'd3);
    #1 reset = 1'b0;
    #1;
    chk("t1_strobe_drop", 64'({mem_en, mem_we}), 64'd0);
    if_req = 0; dm_req = 0; dm_we = 0;
    repeat (2) begin
      @(negedge clk);
      chk("t1_quiet_in_reset", 64'({dm_rvalid, if_rvalid, dm_gnt, if_gnt}), 64'd0);
    end
    #2 reset = 1'b1;

    // Both requesters held: fetch forced after STARVE_MAX data grants.
    gseq = "";
    @(negedge clk);
    if_req = 1; if_addr = 64'h300;
    dm_req = 1; dm_we = 0; dm_addr = 64'h400;
    obs = ""; n = 0;
    while (obs.len() < 10 && n < 200) begin
      @(negedge clk); n++;
      if (dm_gnt) obs = {obs, "D"};
      if (if_gnt) obs = {obs, "F"};
    end
    if_req = 0; dm_req = 0;
    chk_s("t3_dut_order", obs, "DDDDFDDDDF");
    chk_s("t3_model_order", gseq, "DDDDFDDDDF");
    repeat (6) @(negedge clk);

    // Lone load, MEM_LAT=1.
    dm_op(1'b0, 64'h100, 64'd0, rd, er, gc, rc, sc, mg, ma);
    chk("t2_gnt_cycle", 64'(gc - sc), 64'd1);
    chk("t2_men_at_gnt", 64'(mg), 64'd1);
    chk("t2_addr_at_gnt", ma, 64'h100);
    chk("t2_rvalid_lat", 64'(rc - gc), 64'd1);
    chk("t2_rdata", rd, 64'h1122334455667788);
    chk("t2_err", 64'(er), 64'd0);

    // Store then fetch the same address.
    wcnt = 0;
    dm_op(1'b1, 64'h200, 64'hDEADBEEF, rd, er, gc, rc, sc, mg, ma);
    chk("t4_one_write", 64'(wcnt), 64'd1);
    chk("t4_store_rdata", rd, 64'd0);
    if_op(64'h200, r32, er, gc, rc);
    chk("t4_fetch", 64'(r32), 64'hDEADBEEF);
    chk("t4_fetch_err", 64'(er), 64'd0);
    dm_op(1'b0, 64'h500, 64'd0, rd, er, gc, rc, sc, mg, ma);
    chk("t1_no_partial_write", rd, 64'd0);

    // Range boundaries.
    ecnt = 0;
    dm_op(1'b0, MB - 64'd4, 64'd0, rd, er, gc, rc, sc, mg, ma);
    chk("t5_no_mem_en", 64'(ecnt), 64'd0);
    chk("t5_dm_err", 64'(er), 64'd1);
    chk("t5_dm_rdata", rd, 64'd0);
    chk("t5_err_lat", 64'(rc - gc), 64'd1);
    if_op(MB - 64'd4, r32, er, gc, rc);
    chk("t5_if_err", 64'(er), 64'd0);
    chk("t5_if_rdata", 64'(r32), 64'h01234567);
    dm_op(1'b0, MB - 64'd8, 64'd0, rd, er, gc, rc, sc, mg, ma);
    chk("t5_dm_last_ok", {63'd0, er} | (rd ^ 64'h0123456789ABCDEF), 64'd0);
    if_op(MB - 64'd3, r32, er, gc, rc);
    chk("t5_if_over", 64'({er, r32}), 64'h1_0000_0000);
    dm_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, rd, er, gc, rc, sc, mg, ma);
    chk("t5_dm_wrap", 64'(er), 64'd1);

    // MEM_LAT=3 fetch and load on the second instance.
    e3cnt = 0;
    @(negedge clk);
    if3_req = 1; if3_addr = 64'h2000; sc = cyc;
    n = 0;
    do begin @(negedge clk); n++; end while (!if3_gnt && n < 20);
    chk("t6_gnt_seen", 64'(if3_gnt), 64'd1);
    gc = cyc; if3_req = 0;
    chk("t6_gnt_cycle", 64'(gc - sc), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("t6_addr_hold", mem3_addr, 64'h2000);
    end
    n = 0;
    while (!if3_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("t6_rvalid_seen", 64'(if3_rvalid), 64'd1);
    chk("t6_rvalid_lat", 64'(cyc - gc), 64'd3);
    chk("t6_rdata", 64'(if3_rdata), 64'h44332211);
    chk("t6_err", 64'(if3_err), 64'd0);
    chk("t6_one_strobe", 64'(e3cnt), 64'd1);
    @(negedge clk);
    dm3_req = 1; dm3_addr = 64'h100;
    n = 0;
    do begin @(negedge clk); n++; end while (!dm3_gnt && n < 20);
    gc = cyc; dm3_req = 0;
    n = 0;
    while (!dm3_rvalid && n < 20) begin @(negedge clk); n++; end
    chk("t6_load_lat", 64'(cyc - gc), 64'd3);
    chk("t6_load_rdata", dm3_rdata, 64'h1122334455667788);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
